// File: rtl/shifter_pkg.sv
// shifter_pkg: shared definitions for the pipelined eBPF shifter.
//   - op code constants (LSH, RSH, ARSH, ROR)
//   - FSM state type
//   - helpers for shift-count width and log-levels per pipeline stage
package shifter_pkg;

  localparam logic [1:0] OP_LSH  = 2'b00;
  localparam logic [1:0] OP_RSH  = 2'b01;
  localparam logic [1:0] OP_ARSH = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Number of shift-count bits (and log-shifter levels) for a word width.
  function automatic int shift_bits(input int dw);
    return $clog2(dw);
  endfunction

  // Log-shifter levels handled per clock when split across 'st' stages.
  function automatic int levels_per_stage(input int dw, input int st);
    return ($clog2(dw) + st - 1) / st;
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: combinational slice of the log shifter.
// Applies the levels belonging to stage i_stage (levels
// i_stage*LPS .. i_stage*LPS+LPS-1); all other levels pass through.
// Rotate support is compiled in only with SHIFTER_ROTATE_EN.
// Ports:
//   i_data   working word
//   i_amt    masked shift count (one bit per level)
//   i_stage  current stage index
//   i_left   1 = shift toward MSB (zero fill)
//   i_fill   bit shifted in at the top on right shifts (ARSH sign)
//   i_rot    rotate right (SHIFTER_ROTATE_EN only)
//   i_narrow alu32 form: operate on bits [31:0], upper bits stay zero
//   o_data   word after this stage's levels
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 1,
  localparam int SW = shift_bits(DATA_WIDTH),
  localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [SW-1:0]         i_amt,
  input  logic [CW-1:0]         i_stage,
  input  logic                  i_left,
  input  logic                  i_fill,
`ifdef SHIFTER_ROTATE_EN
  input  logic                  i_rot,
`endif
  input  logic                  i_narrow,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int LPS = levels_per_stage(DATA_WIDTH, STAGES);

  logic [SW:0][DATA_WIDTH-1:0] w_lvl;

  assign w_lvl[0] = i_data;

  for (genvar l = 0; l < SW; l++) begin : g_lvl
    localparam int K = 1 << l;

    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_wide;
    logic [DATA_WIDTH-1:0] w_nar;

    assign w_en = i_amt[l] && (i_stage == CW'(l / LPS));

    always_comb begin
      if (i_left) w_wide = w_lvl[l] << K;
      else        w_wide = (w_lvl[l] >> K) | (i_fill ? ~({DATA_WIDTH{1'b1}} >> K) : '0);
`ifdef SHIFTER_ROTATE_EN
      if (i_rot)  w_wide = (w_lvl[l] >> K) | (w_lvl[l] << (DATA_WIDTH - K));
`endif
    end

    if (K < 32) begin : g_nar
      logic [31:0] w_lo;
      logic [31:0] w_n;
      assign w_lo = w_lvl[l][31:0];
      // 32-bit form: fill/rotate boundary is bit 31, result zero-extended
      always_comb begin
        if (i_left) w_n = w_lo << K;
        else        w_n = (w_lo >> K) | (i_fill ? ~(32'hFFFF_FFFF >> K) : 32'h0);
`ifdef SHIFTER_ROTATE_EN
        if (i_rot)  w_n = (w_lo >> K) | (w_lo << (32 - K));
`endif
      end
      assign w_nar = DATA_WIDTH'(w_n);
    end else begin : g_nar_none
      // alu32 counts are 5 bits, so levels >= 32 never fire in narrow form
      assign w_nar = w_lvl[l];
    end

    assign w_lvl[l+1] = !w_en ? w_lvl[l] : (i_narrow ? w_nar : w_wide);
  end

  assign o_data = w_lvl[SW];

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: multi-cycle LSH/RSH/ARSH (and optional ROR) for the
// eBPF ALU, 64-bit or alu32 form, with modulo-width count masking.
// The log shifter is spread over STAGES cycles; one shifter_stage
// instance is reused each cycle on a registered working word.
// Optional feature: define SHIFTER_ROTATE_EN to make op=11 a rotate right;
// otherwise op=11 completes with err=1 and out=0.
// Ports:
//   clk, rst   clock (rising) and async active-high reset
//   stb        request strobe, sampled only when idle
//   op         00 LSH, 01 RSH, 10 ARSH, 11 ROR
//   alu32      32-bit form (ignored when DATA_WIDTH==32)
//   value      operand
//   shift      shift count (low bits used)
//   out, err   result and unsupported-op flag, held until the next ack
//   ack        one-cycle completion pulse
//   busy       high from capture through the ack cycle
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stb,
  input  logic [1:0]            op,
  input  logic                  alu32,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [DATA_WIDTH-1:0] shift,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  ack,
  output logic                  err,
  output logic                  busy
);

  localparam int SW = shift_bits(DATA_WIDTH);
  localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_work;
  logic [SW-1:0]         r_amt;
  logic                  r_left;
  logic                  r_fill;
  logic                  r_narrow;
  logic                  r_bad;
`ifdef SHIFTER_ROTATE_EN
  logic                  r_rot;
`endif

  logic                  w_narrow;
  logic [SW-1:0]         w_amt;
  logic                  w_sign;
  logic                  w_bad;
  logic [DATA_WIDTH-1:0] w_stage_out;
  logic                  w_unused;

  assign w_narrow = alu32 && (DATA_WIDTH > 32);
  assign w_amt    = w_narrow ? SW'(shift[4:0]) : shift[SW-1:0];
  assign w_sign   = w_narrow ? value[31] : value[DATA_WIDTH-1];
`ifdef SHIFTER_ROTATE_EN
  assign w_bad    = 1'b0;
`else
  assign w_bad    = (op == OP_ROR);
`endif
  // count bits above the mask are architecturally ignored
  assign w_unused = ^shift[DATA_WIDTH-1:SW];

  shifter_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (STAGES)
  ) u_stage (
    .i_data   (r_work),
    .i_amt    (r_amt),
    .i_stage  (r_cnt),
    .i_left   (r_left),
    .i_fill   (r_fill),
`ifdef SHIFTER_ROTATE_EN
    .i_rot    (r_rot),
`endif
    .i_narrow (r_narrow),
    .o_data   (w_stage_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_amt    <= '0;
      r_left   <= 1'b0;
      r_fill   <= 1'b0;
      r_narrow <= 1'b0;
      r_bad    <= 1'b0;
`ifdef SHIFTER_ROTATE_EN
      r_rot    <= 1'b0;
`endif
      out      <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (stb) begin
            r_work   <= w_narrow ? DATA_WIDTH'(value[31:0]) : value;
            r_amt    <= w_amt;
            r_left   <= (op == OP_LSH);
            r_fill   <= (op == OP_ARSH) && w_sign;
            r_narrow <= w_narrow;
            r_bad    <= w_bad;
`ifdef SHIFTER_ROTATE_EN
            r_rot    <= (op == OP_ROR);
`endif
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_work <= w_stage_out;
          if (r_cnt == CW'(STAGES - 1)) begin
            // only the finished word ever reaches out
            out     <= r_bad ? '0 : w_stage_out;
            err     <= r_bad;
            ack     <= 1'b1;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          ack     <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: three DUTs (STAGES=1,2,3, DATA_WIDTH=64)
// share operands; directed table, random vectors against a model, and
// hand-written handshake / reset sequences.
module tb_pipelined_shifter;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       stb;
  logic [1:0]       op;
  logic             alu32;
  logic [63:0]      value;
  logic [63:0]      shift;
  logic [2:0][63:0] out;
  logic [2:0]       ack;
  logic [2:0]       err;
  logic [2:0]       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipelined_shifter #(.DATA_WIDTH(64), .STAGES(g + 1)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .stb   (stb[g]),
      .op    (op),
      .alu32 (alu32),
      .value (value),
      .shift (shift),
      .out   (out[g]),
      .ack   (ack[g]),
      .err   (err[g]),
      .busy  (busy[g])
    );
  end

  typedef struct {
    logic [1:0]  op;
    logic        a32;
    logic [63:0] v;
    logic [63:0] s;
    logic [63:0] exp;
    logic        e;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: eBPF semantics with plain SV arithmetic shifts.
  function automatic void model(input logic [1:0] o, input logic a, input logic [63:0] v,
                                input logic [63:0] s, output logic [63:0] r, output logic e);
    int          n;
    logic [31:0] w;
    logic [31:0] t;
    e = 1'b0;
    if (a) begin
      n = int'(s % 64'd32);
      w = v[31:0];
      case (o)
        2'd0:    t = w << n;
        2'd1:    t = w >> n;
        2'd2:    t = $signed(w) >>> n;
        default: t = (w >> n) | (w << (32 - n));
      endcase
      r = {32'h0, t};
    end else begin
      n = int'(s % 64'd64);
      case (o)
        2'd0:    r = v << n;
        2'd1:    r = v >> n;
        2'd2:    r = $signed(v) >>> n;
        default: r = (v >> n) | (v << (64 - n));
      endcase
    end
`ifndef SHIFTER_ROTATE_EN
    if (o == 2'd3) begin
      r = '0;
      e = 1'b1;
    end
`endif
  endfunction

  // One request to all three DUTs; checks latency, ack width, busy, result.
  task automatic run(input logic [1:0] o, input logic a, input logic [63:0] v, input logic [63:0] s,
                     input logic [63:0] exp, input logic e, input string name);
    @(negedge clk);
    op = o; alu32 = a; value = v; shift = s; stb = 3'b111;
    @(negedge clk);
    stb = 3'b000;
    // operands change after capture; result must come from captured copy
    op = 2'($urandom); alu32 = 1'($urandom); value = {$urandom, $urandom}; shift = {$urandom, $urandom};
    for (int g = 0; g < 3; g++) check($sformatf("%s S%0d busy n0", name, g + 1), busy[g], 1);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        check($sformatf("%s S%0d ack n%0d", name, g + 1, n), ack[g], (n == g + 1));
        check($sformatf("%s S%0d busy n%0d", name, g + 1, n), busy[g], (n <= g + 1));
        if (n == g + 1 || n == 4) begin
          check($sformatf("%s S%0d out n%0d", name, g + 1, n), out[g], exp);
          check($sformatf("%s S%0d err n%0d", name, g + 1, n), err[g], e);
        end
      end
    end
  endtask

  vec_t        tbl[10];
  logic [63:0] r_exp;
  logic        r_e;

  initial begin
    rst = 1'b1; stb = '0; op = '0; alu32 = 1'b0; value = '0; shift = '0;

    tbl[0] = '{2'd0, 1'b0, 64'h0000_0000_0000_00F0, 64'd4,    64'h0000_0000_0000_0F00, 1'b0};
    tbl[1] = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'h44,   64'hF800_0000_0000_0000, 1'b0};
    tbl[2] = '{2'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h44,   64'h0800_0000_0000_0000, 1'b0};
    tbl[3] = '{2'd2, 1'b1, 64'hDEAD_BEEF_8000_0010, 64'd36,   64'h0000_0000_F800_0001, 1'b0};
`ifdef SHIFTER_ROTATE_EN
    tbl[4] = '{2'd3, 1'b0, 64'h1,                   64'd1,    64'h8000_0000_0000_0000, 1'b0};
`else
    tbl[4] = '{2'd3, 1'b0, 64'h1,                   64'd1,    64'h0,                   1'b1};
`endif
    tbl[5] = '{2'd0, 1'b1, 64'hFFFF_FFFF_1234_5678, 64'h40,   64'h0000_0000_1234_5678, 1'b0};
    tbl[6] = '{2'd0, 1'b0, 64'h1,                   64'd63,   64'h8000_0000_0000_0000, 1'b0};
    tbl[7] = '{2'd0, 1'b1, 64'hFFFF_FFFF,           64'd31,   64'h0000_0000_8000_0000, 1'b0};
    tbl[8] = '{2'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31,   64'h0000_0000_0000_0001, 1'b0};
    tbl[9] = '{2'd2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd127,  64'h0,                   1'b0};

    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset S%0d out", g + 1), out[g], 0);
      check($sformatf("reset S%0d ack", g + 1), ack[g], 0);
      check($sformatf("reset S%0d err", g + 1), err[g], 0);
      check($sformatf("reset S%0d busy", g + 1), busy[g], 0);
    end
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run(tbl[i].op, tbl[i].a32, tbl[i].v, tbl[i].s, tbl[i].exp, tbl[i].e, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic        a;
      logic [63:0] v;
      logic [63:0] s;
      o = 2'($urandom_range(0, 3));
      a = 1'($urandom);
      v = {$urandom, $urandom};
      s = {$urandom, $urandom};
      model(o, a, v, s, r_exp, r_e);
      run(o, a, v, s, r_exp, r_e, $sformatf("rnd%0d", i));
    end

    // STAGES=3: stb held through RUN and the ACK edge yields one ack only
    @(negedge clk);
    op = 2'd0; alu32 = 1'b0; value = 64'h1; shift = 64'd1; stb = 3'b100;
    @(negedge clk);
    value = 64'hFF; shift = 64'd2;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check($sformatf("hold ack n%0d", n), ack[2], (n == 3));
      check($sformatf("hold busy n%0d", n), busy[2], (n <= 3));
      if (n == 3) check("hold out", out[2], 64'h2);
      if (n == 4) stb = 3'b000;
    end

    // Reset one cycle after capture: async clear, request abandoned
    run(2'd0, 1'b0, 64'h5, 64'd3, 64'h28, 1'b0, "pre_rst");
    @(negedge clk);
    op = 2'd0; alu32 = 1'b0; value = 64'h3; shift = 64'd1; stb = 3'b111;
    @(negedge clk);
    stb = 3'b000;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("midrst S%0d out", g + 1), out[g], 0);
      check($sformatf("midrst S%0d ack", g + 1), ack[g], 0);
      check($sformatf("midrst S%0d err", g + 1), err[g], 0);
      check($sformatf("midrst S%0d busy", g + 1), busy[g], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        check($sformatf("postrst S%0d ack n%0d", g + 1, n), ack[g], 0);
    end
    run(2'd1, 1'b0, 64'hF000_0000_0000_0000, 64'd8, 64'h00F0_0000_0000_0000, 1'b0, "fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
